msrv32_dmem_access_ctrl: RTL and testbench

- Consumer end of the execute-stage register outputs: takes the registered effective address (iadder), store data (rs2), load size and load-unsigned, and runs the data-memory bus transaction.
- Drives a valid/ready request channel and a separate read-response channel to data memory.
- Aligns store data and byte masks, extracts and extends load data, and stalls the pipeline until the access completes.
- Sits between the execute-stage register and the writeback mux.

---
 rtl/msrv32_dmem_access_ctrl.sv | 88 ++++++++
 tb/tb_msrv32_dmem_access_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_dmem_access_ctrl.sv
// msrv32_dmem_access_ctrl: runs one data-memory load/store transaction at a time, aligning data and stalling the pipeline.
module msrv32_dmem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        ld_req_in,
  input  logic        st_req_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wdata_out,
  output logic [3:0]  dmem_wmask_out,
  input  logic        dmem_ready_in,
  input  logic        dmem_rvalid_in,
  input  logic [31:0] dmem_rdata_in,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic        store_done_out,
  output logic        stall_out,
  output logic        misaligned_out,
  output logic        bus_err_out
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_t;
  localparam logic [31:0] TMAX = 32'(TIMEOUT) - 32'd1;
  state_t state, state_next;
  logic [31:0] addr_q, rs2_q, cnt, wdata, shifted, ld_val;
  logic [1:0] size_q;
  logic [3:0] wmask;
  logic uns_q, st_q, req_any, mis, accept, busy, hs, tmo;
  always_comb begin
    req_any = ld_req_in | st_req_in;
    mis = (load_size_in == 2'b01 && iadder_in[0]) || (load_size_in[1] && iadder_in[1:0] != 2'b00);
    accept = state == IDLE && req_any && !mis;
    busy = state == REQ || state == WAIT_RESP;
    hs = state == REQ ? dmem_ready_in : (state == WAIT_RESP) && dmem_rvalid_in;
    tmo = (TIMEOUT != 0) && busy && !hs && cnt == TMAX;
    state_next = accept ? REQ :
                 (state == REQ && hs) ? (st_q ? DONE : WAIT_RESP) :
                 (state == WAIT_RESP && hs) ? DONE :
                 (tmo || state == DONE) ? IDLE : state;
    wdata = size_q == 2'b00 ? {4{rs2_q[7:0]}} : size_q == 2'b01 ? {2{rs2_q[15:0]}} : rs2_q;
    wmask = size_q == 2'b00 ? 4'b0001 << addr_q[1:0] : size_q == 2'b01 ? 4'b0011 << addr_q[1:0] : 4'b1111;
    shifted = dmem_rdata_in >> {addr_q[1:0], 3'b000};
    ld_val = size_q == 2'b00 ? {{24{~uns_q & shifted[7]}}, shifted[7:0]} :
             size_q == 2'b01 ? {{16{~uns_q & shifted[15]}}, shifted[15:0]} : shifted;
    // Bus outputs are decoded from state so an async reset drops them at once.
    dmem_req_out = state == REQ;
    dmem_we_out = state == REQ && st_q;
    dmem_addr_out = state == REQ ? {addr_q[31:2], 2'b00} : 32'd0;
    dmem_wdata_out = dmem_we_out ? wdata : 32'd0;
    dmem_wmask_out = dmem_we_out ? wmask : 4'b0000;
    load_valid_out = state == DONE && !st_q;
    store_done_out = state == DONE && st_q;
    stall_out = accept || busy;
  end
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      rs2_q <= '0;
      size_q <= '0;
      uns_q <= 1'b0;
      st_q <= 1'b0;
      load_data_out <= '0;
      misaligned_out <= 1'b0;
      bus_err_out <= 1'b0;
    end else begin
      state <= state_next;
      cnt <= (state_next != state) ? '0 : busy ? cnt + 32'd1 : '0;
      if (accept) begin
        addr_q <= iadder_in;
        rs2_q <= rs2_in;
        size_q <= load_size_in;
        uns_q <= load_unsigned_in;
        st_q <= st_req_in;
      end
      if (state == WAIT_RESP && hs) load_data_out <= ld_val;
      misaligned_out <= state == IDLE && req_any && mis;
      bus_err_out <= tmo;
    end
  end
endmodule

// File: tb/tb_msrv32_dmem_access_ctrl.sv
// tb_msrv32_dmem_access_ctrl: directed and random transactions checked against a byte-lane transaction model.
module tb_msrv32_dmem_access_ctrl;
  localparam int TO = 4;
  logic clk_in = 0, reset_in;
  logic ld_req_in, st_req_in, load_unsigned_in;
  logic [31:0] iadder_in, rs2_in, dmem_rdata_in;
  logic [1:0] load_size_in;
  logic dmem_ready_in, dmem_rvalid_in;
  logic dmem_req_out, dmem_we_out, load_valid_out, store_done_out, stall_out, misaligned_out, bus_err_out;
  logic [31:0] dmem_addr_out, dmem_wdata_out, load_data_out;
  logic [3:0] dmem_wmask_out;
  int checks = 0, errors = 0;
  logic [31:0] exp_ld = 0;
  msrv32_dmem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .ld_req_in(ld_req_in), .st_req_in(st_req_in),
    .iadder_in(iadder_in), .rs2_in(rs2_in), .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in),
    .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out), .dmem_addr_out(dmem_addr_out),
    .dmem_wdata_out(dmem_wdata_out), .dmem_wmask_out(dmem_wmask_out), .dmem_ready_in(dmem_ready_in),
    .dmem_rvalid_in(dmem_rvalid_in), .dmem_rdata_in(dmem_rdata_in), .load_data_out(load_data_out),
    .load_valid_out(load_valid_out), .store_done_out(store_done_out), .stall_out(stall_out),
    .misaligned_out(misaligned_out), .bus_err_out(bus_err_out)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_req"}, 32'(dmem_req_out), 0);
    chk({tag, "_stall"}, 32'(stall_out), 0);
    chk({tag, "_lvalid"}, 32'(load_valid_out), 0);
    chk({tag, "_sdone"}, 32'(store_done_out), 0);
    chk({tag, "_ldata"}, load_data_out, exp_ld);
  endtask
  task automatic chk_timeout();
    chk("tmo_buserr", 32'(bus_err_out), 1);
    chk_idle("tmo");
    tick();
    chk("tmo_buserr_clr", 32'(bus_err_out), 0);
    chk_idle("tmo_after");
  endtask
  task automatic run_txn(input bit ld, input bit st, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input bit uns, input int rdy_dly, input int rv_dly,
                         input logic [31:0] rd);
    int n, off;
    bit mis, hs;
    logic [3:0] m;
    logic [31:0] w, l;
    n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    off = int'(a[1:0]);
    mis = (off % n) != 0;
    m = '0;
    w = '0;
    l = '0;
    for (int b = 0; b < 4; b++) begin
      m[b] = b >= off && b < off + n;
      w[8*b +: 8] = d[8*(b % n) +: 8];
    end
    for (int k = 0; k < n; k++) l[8*k +: 8] = rd[8*((off + k) % 4) +: 8];
    if (!uns && n < 4 && l[8*n-1]) l = l - (32'd1 << (8*n));
    ld_req_in = ld; st_req_in = st; iadder_in = a; rs2_in = d; load_size_in = sz; load_unsigned_in = uns;
    #1;
    chk("accept_stall", 32'(stall_out), 32'(!mis));
    chk("accept_req", 32'(dmem_req_out), 0);
    tick();
    ld_req_in = 0; st_req_in = 0; iadder_in = $urandom; rs2_in = $urandom;
    load_size_in = 2'($urandom_range(0, 3)); load_unsigned_in = 1'($urandom_range(0, 1));
    if (mis) begin
      chk("mis_pulse", 32'(misaligned_out), 1);
      chk_idle("mis");
      tick();
      chk("mis_clr", 32'(misaligned_out), 0);
      chk_idle("mis_after");
      return;
    end
    hs = 0;
    for (int i = 0; i < TO; i++) begin
      dmem_ready_in = i == rdy_dly;
      dmem_rvalid_in = i == rdy_dly;
      dmem_rdata_in = $urandom;
      #1;
      chk("req_valid", 32'(dmem_req_out), 1);
      chk("req_stall", 32'(stall_out), 1);
      chk("req_we", 32'(dmem_we_out), 32'(st));
      chk("req_addr", dmem_addr_out, {a[31:2], 2'b00});
      chk("req_mask", 32'(dmem_wmask_out), st ? 32'(m) : 0);
      if (st) chk("req_wdata", dmem_wdata_out, w);
      tick();
      dmem_ready_in = 0;
      dmem_rvalid_in = 0;
      if (i == rdy_dly) begin
        hs = 1;
        break;
      end
    end
    if (!hs) begin
      chk_timeout();
      return;
    end
    if (st) begin
      chk("st_done", 32'(store_done_out), 1);
      chk("st_lvalid", 32'(load_valid_out), 0);
      chk("st_stall", 32'(stall_out), 0);
      tick();
      chk_idle("st_after");
      return;
    end
    hs = 0;
    for (int i = 0; i < TO; i++) begin
      dmem_rvalid_in = i == rv_dly;
      dmem_rdata_in = i == rv_dly ? rd : $urandom;
      #1;
      chk("wait_req", 32'(dmem_req_out), 0);
      chk("wait_stall", 32'(stall_out), 1);
      tick();
      dmem_rvalid_in = 0;
      if (i == rv_dly) begin
        hs = 1;
        break;
      end
    end
    if (!hs) begin
      chk_timeout();
      return;
    end
    exp_ld = l;
    chk("ld_valid", 32'(load_valid_out), 1);
    chk("ld_sdone", 32'(store_done_out), 0);
    chk("ld_stall", 32'(stall_out), 0);
    chk("ld_data", load_data_out, exp_ld);
    tick();
    chk_idle("ld_after");
  endtask
  initial begin
    logic [31:0] r, a;
    logic [1:0] sz;
    bit ld, st;
    reset_in = 1; ld_req_in = 0; st_req_in = 0; iadder_in = 0; rs2_in = 0; load_size_in = 0;
    load_unsigned_in = 0; dmem_ready_in = 0; dmem_rvalid_in = 0; dmem_rdata_in = 0;
    #1;
    chk("rst_busout", {dmem_addr_out[31:4], dmem_wmask_out} | dmem_wdata_out, 0);
    chk("rst_pulses", 32'({misaligned_out, bus_err_out, dmem_we_out}), 0);
    chk_idle("rst");
    tick();
    tick();
    reset_in = 0;
    run_txn(0, 1, 32'h1003, 32'hAABBCCDD, 2'd0, 0, 1, 0, 0);
    run_txn(1, 0, 32'h2002, 0, 2'd0, 0, 0, 0, 32'h0080FF00);
    chk("dir_lb_s", exp_ld, 32'hFFFFFF80);
    run_txn(1, 0, 32'h2002, 0, 2'd0, 1, 0, 0, 32'h0080FF00);
    chk("dir_lb_u", load_data_out, 32'h00000080);
    run_txn(1, 0, 32'h2002, 0, 2'd1, 0, 1, 1, 32'h80011234);
    chk("dir_lh_s", load_data_out, 32'hFFFF8001);
    run_txn(1, 0, 32'h2002, 0, 2'd1, 1, 0, 2, 32'h80011234);
    chk("dir_lh_u", load_data_out, 32'h00008001);
    run_txn(1, 0, 32'h2000, 0, 2'd2, 0, 2, 0, 32'h80011234);
    chk("dir_lw", load_data_out, 32'h80011234);
    run_txn(1, 0, 32'h3001, 0, 2'd2, 0, 0, 0, 0);
    run_txn(0, 1, 32'h3003, 32'h12345678, 2'd1, 0, 0, 0, 0);
    run_txn(1, 0, 32'h4000, 0, 2'd2, 0, 99, 0, 0);
    run_txn(1, 0, 32'h4004, 0, 2'd0, 0, 0, 99, 0);
    ld_req_in = 1; iadder_in = 32'h5000; load_size_in = 2'd2;
    tick();
    ld_req_in = 0;
    dmem_ready_in = 1;
    tick();
    dmem_ready_in = 0;
    #2 reset_in = 1;
    #1;
    exp_ld = 0;
    chk_idle("midrst");
    chk("midrst_pulses", 32'({misaligned_out, bus_err_out, dmem_we_out}), 0);
    #2 reset_in = 0;
    tick();
    chk_idle("postrst");
    run_txn(1, 0, 32'h6001, 0, 2'd0, 0, 0, 1, 32'hCAFE7F00);
    chk("postrst_ld", load_data_out, 32'h0000007F);
    run_txn(1, 1, 32'h7002, 32'h0000BEEF, 2'd1, 0, 0, 0, 32'hFFFFFFFF);
    chk("both_keep_ld", load_data_out, 32'h0000007F);
    for (int t = 0; t < 60; t++) begin
      r = $urandom;
      sz = 2'($urandom_range(0, 3));
      a = {r[31:2], 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 4) != 0) a[1:0] = sz == 2'd0 ? a[1:0] : sz == 2'd1 ? {a[1], 1'b0} : 2'b00;
      ld = 1'($urandom_range(0, 1));
      st = 1'($urandom_range(0, 1));
      if (!ld && !st) ld = 1;
      run_txn(ld, st, a, $urandom, sz, 1'($urandom_range(0, 1)),
              $urandom_range(0, 9) == 0 ? 99 : int'($urandom_range(0, 2)),
              $urandom_range(0, 9) == 0 ? 99 : int'($urandom_range(0, 2)), $urandom);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
